// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register-file write arbiter slice.
//   DW        : default write-data width
//   AW        : default register address width
//   ZERO_REG  : architectural zero register (writes to it are dropped)
//   REQ_ALU   : requester id of the ALU writeback port (requester 0)
//   REQ_LD    : requester id of the load-unit port (requester 1)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way grant logic for the register-file write port.
// A lone valid requester always wins. When both are valid the winner is the
// requester named by the round-robin pointer (REGFILE_WR_ARB_RR_EN defined) or
// requester 1 (macro undefined, no pointer flop is built).
// rf busy blocks every ready. Readies are purely combinational.
//
// Optional feature macro: REGFILE_WR_ARB_RR_EN
//
// Ports:
//   clk, rst  : clock / async active-low reset (only with REGFILE_WR_ARB_RR_EN)
//   valid0/1  : requester valids
//   busy      : register file cannot accept a write
//   ready0/1  : one-hot (or zero) accept strobes
//   grant     : id of the requester the grant logic is selecting
// -----------------------------------------------------------------------------
module rr_arb2 (
`ifdef REGFILE_WR_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic valid0,
    input  logic valid1,
    input  logic busy,
    output logic ready0,
    output logic ready1,
    output logic grant
);
    import regfile_pkg::*;

    logic both_pick_s;
    logic grant_s;
    logic xfer_s;

`ifdef REGFILE_WR_ARB_RR_EN
    logic ptr_r;

    // Pointer moves to the loser of each transfer, so the other side wins next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= REQ_ALU;
        end else if (xfer_s) begin
            ptr_r <= ~grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign both_pick_s = ptr_r;
`else
    assign both_pick_s = REQ_LD;
`endif

    // Select the winner and gate the readies with rf busy.
    always_comb begin
        grant_s = REQ_ALU;
        xfer_s  = 1'b0;
        ready0  = 1'b0;
        ready1  = 1'b0;
        if (valid0 && valid1) begin
            grant_s = both_pick_s;
        end else if (valid1) begin
            grant_s = REQ_LD;
        end else begin
            grant_s = REQ_ALU;
        end
        xfer_s = !busy && (valid0 || valid1);
        // With xfer_s high, a grant to a side implies that side is valid.
        ready0 = xfer_s && (grant_s == REQ_ALU);
        ready1 = xfer_s && (grant_s == REQ_LD);
    end

    assign grant = grant_s;

endmodule : rr_arb2

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Arbitrates two writeback sources (ALU, load unit) onto a single register
// file write port. An accepted write appears on rf_* one cycle after the
// accepting edge; writes to the zero register are accepted but not strobed.
//
// Optional feature macro: REGFILE_WR_ARB_RR_EN (round-robin on ties;
// otherwise requester 1 always wins a tie).
//
// Ports:
//   clk                      : clock, rising edge
//   rst                      : asynchronous reset, active low
//   req0_valid/rd/data/ready : ALU writeback handshake
//   req1_valid/rd/data/ready : load-unit writeback handshake
//   rf_busy                  : register file cannot accept a write
//   rf_we / rf_wa / rf_wd    : registered register-file write strobe/addr/data
//   grant_id                 : requester that owns the current rf_* contents
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DW = regfile_pkg::DW,
    parameter int AW = regfile_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_rd,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_rd,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          rf_busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          grant_id
);
    import regfile_pkg::*;

    logic          grant_s;
    logic          ready0_s;
    logic          ready1_s;
    logic          xfer_s;
    logic [AW-1:0] sel_rd_s;
    logic [DW-1:0] sel_data_s;

    logic          rf_we_r;
    logic [AW-1:0] rf_wa_r;
    logic [DW-1:0] rf_wd_r;
    logic          grant_id_r;

    rr_arb2 u_arb (
`ifdef REGFILE_WR_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .busy   (rf_busy),
        .ready0 (ready0_s),
        .ready1 (ready1_s),
        .grant  (grant_s)
    );

    assign xfer_s = ready0_s || ready1_s;

    // Steer the winning requester's address and data toward the output register.
    always_comb begin
        sel_rd_s   = req0_rd;
        sel_data_s = req0_data;
        if (grant_s == REQ_LD) begin
            sel_rd_s   = req1_rd;
            sel_data_s = req1_data;
        end else begin
            sel_rd_s   = req0_rd;
            sel_data_s = req0_data;
        end
    end

    // Output register: capture an accepted write, otherwise drop the strobe and hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_r    <= 1'b0;
            rf_wa_r    <= {AW{1'b0}};
            rf_wd_r    <= {DW{1'b0}};
            grant_id_r <= REQ_ALU;
        end else if (xfer_s) begin
            rf_we_r    <= (sel_rd_s != AW'(ZERO_REG));
            rf_wa_r    <= sel_rd_s;
            rf_wd_r    <= sel_data_s;
            grant_id_r <= grant_s;
        end else begin
            rf_we_r    <= 1'b0;
            rf_wa_r    <= rf_wa_r;
            rf_wd_r    <= rf_wd_r;
            grant_id_r <= grant_id_r;
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign rf_we      = rf_we_r;
    assign rf_wa      = rf_wa_r;
    assign rf_wd      = rf_wd_r;
    assign grant_id   = grant_id_r;

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Self-checking bench for regfile_wr_arbiter. A behavioural model tracks the
// tie-break preference and the last accepted write; each scenario task drives
// inputs, checks the readies mid-cycle and the rf_* outputs just after the edge.
// Build with or without REGFILE_WR_ARB_RR_EN; the model follows the same macro.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic [AW-1:0] req0_rd;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_rd;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rf_busy;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          grant_id;

    int total;
    int bad;

    // Model state: who wins the next tie, and the last write put on the port.
    logic          m_ptr;
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic          m_gid;

    regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_busy    (rf_busy),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {req0_ready, req1_ready} from the current inputs.
    function automatic logic [1:0] exp_ready();
        logic winner;
        if (rf_busy || (!req0_valid && !req1_valid)) return 2'b00;
        if (req0_valid && req1_valid) begin
`ifdef REGFILE_WR_ARB_RR_EN
            winner = m_ptr;
`else
            winner = 1'b1;
`endif
            return winner ? 2'b01 : 2'b10;
        end
        return {req0_valid, req1_valid};
    endfunction

    function automatic logic [AW+DW+1:0] exp_out();
        return {m_we, m_wa, m_wd, m_gid};
    endfunction

    // Advance the model across one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [1:0] r;
        r = exp_ready();
        if (r == 2'b10) begin
            m_we = (req0_rd != 5'd0); m_wa = req0_rd; m_wd = req0_data; m_gid = 1'b0; m_ptr = 1'b1;
        end else if (r == 2'b01) begin
            m_we = (req1_rd != 5'd0); m_wa = req1_rd; m_wd = req1_data; m_gid = 1'b1; m_ptr = 1'b0;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 1'b0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_gid = 1'b0;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                         input logic b);
        req0_valid = v0; req0_rd = r0; req0_data = d0;
        req1_valid = v1; req1_rd = r1; req1_data = d1;
        rf_busy = b;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        model_reset();
        #2;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {rf_we, rf_wa, rf_wd, grant_id});
        end
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_alu();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL single_alu_ready: got %b want 10", {req0_ready, req1_ready});
        end
        @(posedge clk); model_edge(); #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("FAIL single_alu_out: got %h want %h", {rf_we, rf_wa, rf_wd, grant_id},
                     {1'b1, 5'd5, 32'hDEADBEEF, 1'b0});
        end
        // Idle cycle: strobe drops, address/data/grant hold.
        drive(1'b0, 5'd9, 32'h0, 1'b0, 5'd9, 32'h0, 1'b0);
        @(posedge clk); model_edge(); #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
            bad++;
            $display("FAIL idle_hold: got %h want %h", {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
        end
    endtask

    task automatic test_rd_zero();
        drive(1'b0, 5'd3, 32'h0, 1'b1, 5'd0, 32'h12345678, 1'b0);
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rd_zero_ready: got %b want 01", {req0_ready, req1_ready});
        end
        @(posedge clk); model_edge(); #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== {1'b0, 5'd0, 32'h12345678, 1'b1}) begin
            bad++;
            $display("FAIL rd_zero_out: got %h want %h", {rf_we, rf_wa, rf_wd, grant_id},
                     {1'b0, 5'd0, 32'h12345678, 1'b1});
        end
    endtask

    // Ties for several cycles: alternating grants with round robin, else requester 1.
    task automatic test_both_valid();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'hA0 + 32'(i), 1'b1, 5'd2, 32'hB0 + 32'(i), 1'b0);
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== exp_ready()) begin
                bad++;
                $display("FAIL both_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_ready());
            end
            @(posedge clk); model_edge(); #1;
            total++;
            if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
                bad++;
                $display("FAIL both_out[%0d]: got %h want %h", i, {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
            end
        end
    endtask

    task automatic test_busy();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd11, 32'hC0DE0000 + 32'(i), 1'b1, 5'd12, 32'hFACE0000 + 32'(i), (i < 3));
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== exp_ready()) begin
                bad++;
                $display("FAIL busy_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_ready());
            end
            @(posedge clk); model_edge(); #1;
            total++;
            if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
                bad++;
                $display("FAIL busy_out[%0d]: got %h want %h", i, {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
            end
        end
    endtask

    // Load unit streams one write per cycle with no gap.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 20), $urandom, 1'b0);
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got %b want 01", i, {req0_ready, req1_ready});
            end
            @(posedge clk); model_edge(); #1;
            total++;
            if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
                bad++;
                $display("FAIL b2b_out[%0d]: got %h want %h", i, {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 3) == 0));
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_ready());
            end
            @(posedge clk); model_edge(); #1;
            total++;
            if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
                bad++;
                $display("FAIL rand_out[%0d]: got %h want %h", i, {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
            end
        end
    endtask

    // Reset lands before the accepting edge: the write is lost and state restarts.
    task automatic test_reset_cancel();
        // Leave a visible write on the port and bias the tie pointer toward requester 1.
        drive(1'b1, 5'd30, 32'h55AA55AA, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge clk); model_edge(); #1;
        drive(1'b1, 5'd7, 32'h0BADF00D, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL cancel_ready: got %b want 10", {req0_ready, req1_ready});
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL cancel_async: got %h want 0", {rf_we, rf_wa, rf_wd, grant_id});
        end
        @(posedge clk); #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL cancel_edge: got %h want 0", {rf_we, rf_wa, rf_wd, grant_id});
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, 1'b0);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== exp_ready()) begin
            bad++;
            $display("FAIL post_reset_ready: got %b want %b", {req0_ready, req1_ready}, exp_ready());
        end
        @(posedge clk); model_edge(); #1;
        total++;
        if ({rf_we, rf_wa, rf_wd, grant_id} !== exp_out()) begin
            bad++;
            $display("FAIL post_reset_out: got %h want %h", {rf_we, rf_wa, rf_wd, grant_id}, exp_out());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_alu();
        test_rd_zero();
        test_both_valid();
        test_busy();
        test_back_to_back();
        test_random();
        test_reset_cancel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
